// File: rtl/life_pkg.sv
// Shared types and constants for the Life neighbour evaluation stage.
// Rule constants (B3/S23), FSM states and the next-state function.
package life_pkg;

  localparam int NEIGHBOURS_CNT = 8;
  localparam int NBR_CNT_W      = 4;
  localparam int SLOT_W         = 4;

  localparam logic [NBR_CNT_W-1:0] BIRTH_CNT   = 4'd3;
  localparam logic [NBR_CNT_W-1:0] SURVIVE_CNT = 4'd2;
  localparam logic [SLOT_W-1:0]    LAST_SLOT   = 4'd8;

  // Neighbour offset masks, bit k = neighbour k (row-major around cell)
  localparam logic [NEIGHBOURS_CNT-1:0] NBR_XM = 8'b0010_1001;
  localparam logic [NEIGHBOURS_CNT-1:0] NBR_XP = 8'b1001_0100;
  localparam logic [NEIGHBOURS_CNT-1:0] NBR_YM = 8'b0000_0111;
  localparam logic [NEIGHBOURS_CNT-1:0] NBR_YP = 8'b1110_0000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LAST,
    DONE
  } eval_state_t;

  function automatic logic next_state(
    input logic                 own,
    input logic [NBR_CNT_W-1:0] cnt
  );
    return (cnt == BIRTH_CNT) |
           (own & (cnt == SURVIVE_CNT));
  endfunction

endpackage

// File: rtl/nbr_wrap_adr.sv
// Toroidal correction of neighbour addresses at the field borders.
// Interior neighbours pass through unchanged.
module nbr_wrap_adr
  import life_pkg::*;
#(
  parameter int FIELD_W = 30,
  parameter int FIELD_H = 50,
  parameter int XW      = $clog2(FIELD_W),
  parameter int YW      = $clog2(FIELD_H)
) (
  input  logic [XW-1:0]                     i_cell_x_adr,
  input  logic [YW-1:0]                     i_cell_y_adr,
  input  logic [NEIGHBOURS_CNT-1:0][XW-1:0] i_nbrs_x_adr,
  input  logic [NEIGHBOURS_CNT-1:0][YW-1:0] i_nbrs_y_adr,
  output logic [NEIGHBOURS_CNT-1:0][XW-1:0] o_nbrs_x_adr,
  output logic [NEIGHBOURS_CNT-1:0][YW-1:0] o_nbrs_y_adr
);

  localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FIELD_H - 1);

  logic w_x_lo;
  logic w_x_hi;
  logic w_y_lo;
  logic w_y_hi;

  assign w_x_lo = (i_cell_x_adr == '0);
  assign w_x_hi = (i_cell_x_adr == X_MAX);
  assign w_y_lo = (i_cell_y_adr == '0);
  assign w_y_hi = (i_cell_y_adr == Y_MAX);

  // Replace out-of-field coordinates with the opposite border
  always_comb begin
    o_nbrs_x_adr = i_nbrs_x_adr;
    o_nbrs_y_adr = i_nbrs_y_adr;
    for (int k = 0; k < NEIGHBOURS_CNT; k++) begin
      if (NBR_XM[k] && w_x_lo)
        o_nbrs_x_adr[k] = X_MAX;
      else if (NBR_XP[k] && w_x_hi)
        o_nbrs_x_adr[k] = '0;
      if (NBR_YM[k] && w_y_lo)
        o_nbrs_y_adr[k] = Y_MAX;
      else if (NBR_YP[k] && w_y_hi)
        o_nbrs_y_adr[k] = '0;
    end
  end

endmodule

// File: rtl/nbr_state_eval.sv
// Reads a cell and its 8 neighbours, applies B3/S23, emits next state.
// NBR_STATE_EVAL_TORUS_EN selects a toroidal field (all 8 neighbours read).
module nbr_state_eval
  import life_pkg::*;
#(
  parameter  int FIELD_W    = 30,
  parameter  int FIELD_H    = 50,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_req_vld,
  output logic                                      o_req_rdy,
  input  logic [X_ADR_SIZE-1:0]                     i_cell_x_adr,
  input  logic [Y_ADR_SIZE-1:0]                     i_cell_y_adr,
  input  logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] i_nbrs_x_adr,
  input  logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] i_nbrs_y_adr,
  input  logic [NEIGHBOURS_CNT-1:0]                 i_nbrs_rlvnt,
  output logic                                      o_rd_en,
  output logic [X_ADR_SIZE-1:0]                     o_rd_x_adr,
  output logic [Y_ADR_SIZE-1:0]                     o_rd_y_adr,
  input  logic                                      i_rd_data,
  output logic                                      o_res_vld,
  input  logic                                      i_res_rdy,
  output logic [X_ADR_SIZE-1:0]                     o_res_x_adr,
  output logic [Y_ADR_SIZE-1:0]                     o_res_y_adr,
  output logic                                      o_res_state,
  output logic [NBR_CNT_W-1:0]                      o_res_nbr_cnt
);

  eval_state_t r_state;
  eval_state_t w_nxt;

  logic [X_ADR_SIZE-1:0]                     r_cell_x;
  logic [Y_ADR_SIZE-1:0]                     r_cell_y;
  logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] r_nbr_x;
  logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] r_nbr_y;
  logic [NEIGHBOURS_CNT-1:0]                 r_rlvnt;
  logic [SLOT_W-1:0]                         r_idx;
  logic [SLOT_W-1:0]                         r_pend_idx;
  logic                                      r_rd_pend;
  logic [NBR_CNT_W-1:0]                      r_cnt;
  logic                                      r_own;

  logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] w_nbr_x;
  logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] w_nbr_y;
  logic [NEIGHBOURS_CNT-1:0]                 w_rlvnt;
  logic                                      w_hs;
  logic                                      w_done;
  logic                                      w_slot_nbr;
  logic [2:0]                                w_sel;

`ifdef NBR_STATE_EVAL_TORUS_EN
  nbr_wrap_adr #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H),
    .XW      (X_ADR_SIZE),
    .YW      (Y_ADR_SIZE)
  ) u_wrap (
    .i_cell_x_adr (r_cell_x),
    .i_cell_y_adr (r_cell_y),
    .i_nbrs_x_adr (r_nbr_x),
    .i_nbrs_y_adr (r_nbr_y),
    .o_nbrs_x_adr (w_nbr_x),
    .o_nbrs_y_adr (w_nbr_y)
  );
  assign w_rlvnt = '1;
`else
  assign w_nbr_x = r_nbr_x;
  assign w_nbr_y = r_nbr_y;
  assign w_rlvnt = r_rlvnt;
`endif

  assign w_hs       = i_req_vld && o_req_rdy;
  assign w_done     = (r_state == DONE);
  assign w_slot_nbr = (r_idx != '0);
  assign w_sel      = r_idx[2:0] - 3'd1;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_nxt = READ;
      READ:    if (r_idx == LAST_SLOT) w_nxt = LAST;
      LAST:    w_nxt = DONE;
      DONE:    if (i_res_rdy) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Read strobe/address for the current slot and result outputs
  always_comb begin
    o_req_rdy  = (r_state == IDLE);
    o_rd_en    = 1'b0;
    o_rd_x_adr = '0;
    o_rd_y_adr = '0;
    if (r_state == READ) begin
      unique case (1'b1)
        !w_slot_nbr: begin
          o_rd_en    = 1'b1;
          o_rd_x_adr = r_cell_x;
          o_rd_y_adr = r_cell_y;
        end
        w_slot_nbr: begin
          o_rd_en = w_rlvnt[w_sel];
          if (w_rlvnt[w_sel]) begin
            o_rd_x_adr = w_nbr_x[w_sel];
            o_rd_y_adr = w_nbr_y[w_sel];
          end
        end
      endcase
    end
    o_res_vld     = w_done;
    o_res_x_adr   = w_done ? r_cell_x : '0;
    o_res_y_adr   = w_done ? r_cell_y : '0;
    o_res_state   = w_done & next_state(r_own, r_cnt);
    o_res_nbr_cnt = w_done ? r_cnt : '0;
  end

  // Request capture and slot sequencing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cell_x <= '0;
      r_cell_y <= '0;
      r_nbr_x  <= '0;
      r_nbr_y  <= '0;
      r_rlvnt  <= '0;
      r_idx    <= '0;
    end else if (w_hs) begin
      r_cell_x <= i_cell_x_adr;
      r_cell_y <= i_cell_y_adr;
      r_nbr_x  <= i_nbrs_x_adr;
      r_nbr_y  <= i_nbrs_y_adr;
      r_rlvnt  <= i_nbrs_rlvnt;
      r_idx    <= '0;
    end else if (r_state == READ && r_idx != LAST_SLOT) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  // Absorb read data one cycle after each strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend  <= 1'b0;
      r_pend_idx <= '0;
      r_cnt      <= '0;
      r_own      <= 1'b0;
    end else begin
      r_rd_pend  <= o_rd_en;
      r_pend_idx <= r_idx;
      if (w_hs) begin
        r_cnt <= '0;
        r_own <= 1'b0;
      end else if (r_rd_pend) begin
        if (r_pend_idx == '0) r_own <= i_rd_data;
        else                  r_cnt <= r_cnt + {3'b000, i_rd_data};
      end
    end
  end

endmodule

// File: tb/tb_nbr_state_eval.sv
// Directed bench for nbr_state_eval (planar build).
// Field RAM model answers one cycle after each read strobe.
module tb_nbr_state_eval;

  localparam int XW = 5;
  localparam int YW = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_req_vld = 1'b0;
  logic                 o_req_rdy;
  logic [XW-1:0]        i_cell_x_adr = '0;
  logic [YW-1:0]        i_cell_y_adr = '0;
  logic [7:0][XW-1:0]   i_nbrs_x_adr = '0;
  logic [7:0][YW-1:0]   i_nbrs_y_adr = '0;
  logic [7:0]           i_nbrs_rlvnt = '0;
  logic                 o_rd_en;
  logic [XW-1:0]        o_rd_x_adr;
  logic [YW-1:0]        o_rd_y_adr;
  logic                 i_rd_data = 1'b0;
  logic                 o_res_vld;
  logic                 i_res_rdy = 1'b0;
  logic [XW-1:0]        o_res_x_adr;
  logic [YW-1:0]        o_res_y_adr;
  logic                 o_res_state;
  logic [3:0]           o_res_nbr_cnt;

  nbr_state_eval dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_vld     (i_req_vld),
    .o_req_rdy     (o_req_rdy),
    .i_cell_x_adr  (i_cell_x_adr),
    .i_cell_y_adr  (i_cell_y_adr),
    .i_nbrs_x_adr  (i_nbrs_x_adr),
    .i_nbrs_y_adr  (i_nbrs_y_adr),
    .i_nbrs_rlvnt  (i_nbrs_rlvnt),
    .o_rd_en       (o_rd_en),
    .o_rd_x_adr    (o_rd_x_adr),
    .o_rd_y_adr    (o_rd_y_adr),
    .i_rd_data     (i_rd_data),
    .o_res_vld     (o_res_vld),
    .i_res_rdy     (i_res_rdy),
    .o_res_x_adr   (o_res_x_adr),
    .o_res_y_adr   (o_res_y_adr),
    .o_res_state   (o_res_state),
    .o_res_nbr_cnt (o_res_nbr_cnt)
  );

  always #5 clk = ~clk;

  bit ram [50][30];
  int checks = 0;
  int errors = 0;
  logic [XW-1:0] rdx_q[$];
  logic [YW-1:0] rdy_q[$];
  int dxs[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int dys[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  // RAM answers a strobe one cycle later; drives 1 when nothing was read
  always @(posedge clk)
    i_rd_data <= o_rd_en ? ram[o_rd_y_adr][o_rd_x_adr] : 1'b1;

  always @(negedge clk)
    if (o_rd_en) begin
      rdx_q.push_back(o_rd_x_adr);
      rdy_q.push_back(o_rd_y_adr);
    end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_ram(input bit v);
    for (int y = 0; y < 50; y++)
      for (int x = 0; x < 30; x++)
        ram[y][x] = v;
  endtask

  task automatic req(input int x, input int y, input logic [7:0] rl);
    @(negedge clk);
    chk("req_rdy_before", o_req_rdy, 1);
    rdx_q.delete();
    rdy_q.delete();
    i_cell_x_adr = XW'(x);
    i_cell_y_adr = YW'(y);
    for (int k = 0; k < 8; k++) begin
      i_nbrs_x_adr[k] = XW'(x + dxs[k]);
      i_nbrs_y_adr[k] = YW'(y + dys[k]);
    end
    i_nbrs_rlvnt = rl;
    i_req_vld = 1'b1;
    @(posedge clk);
    #1 i_req_vld = 1'b0;
  endtask

  task automatic wait_res(input bit scramble);
    for (int e = 2; e <= 11; e++) begin
      if (scramble) begin
        @(negedge clk);
        i_cell_x_adr = XW'($urandom_range(0, 29));
        i_cell_y_adr = YW'($urandom_range(0, 49));
        for (int k = 0; k < 8; k++) begin
          i_nbrs_x_adr[k] = XW'($urandom_range(0, 29));
          i_nbrs_y_adr[k] = YW'($urandom_range(0, 49));
        end
        i_nbrs_rlvnt = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (e == 10) chk("vld_edge10", o_res_vld, 0);
      if (e == 10) chk("req_rdy_busy", o_req_rdy, 0);
      if (e == 11) chk("vld_edge11", o_res_vld, 1);
    end
  endtask

  task automatic chk_res(input string tag, input int x, input int y,
                         input int cnt, input int st, input int nrd);
    chk({tag, "_x"}, o_res_x_adr, x);
    chk({tag, "_y"}, o_res_y_adr, y);
    chk({tag, "_cnt"}, o_res_nbr_cnt, cnt);
    chk({tag, "_state"}, o_res_state, st);
    chk({tag, "_reads"}, rdx_q.size(), nrd);
  endtask

  task automatic take();
    @(negedge clk);
    i_res_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("take_vld_low", o_res_vld, 0);
    chk("take_req_rdy", o_req_rdy, 1);
    i_res_rdy = 1'b0;
  endtask

  logic [3:0] hold_cnt;

  initial begin
    // reset state, with a request held during reset
    i_req_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_rdy", o_req_rdy, 1);
    chk("rst_res_vld", o_res_vld, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_cnt", o_res_nbr_cnt, 0);
    chk("rst_state", o_res_state, 0);
    chk("rst_res_x", o_res_x_adr, 0);
    i_req_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_idle", o_req_rdy, 1);

    // 1: birth with 3 live neighbours
    clr_ram(0);
    ram[4][4] = 1; ram[4][5] = 1; ram[4][6] = 1;
    req(5, 5, 8'hFF);
    wait_res(0);
    chk_res("t1", 5, 5, 3, 1, 9);
    chk("t1_rd0_x", rdx_q[0], 5);
    chk("t1_rd0_y", rdy_q[0], 5);
    chk("t1_rd1_x", rdx_q[1], 4);
    chk("t1_rd1_y", rdy_q[1], 4);
    chk("t1_rd8_x", rdx_q[8], 6);
    chk("t1_rd8_y", rdy_q[8], 6);
    take();

    // 2a: survive with 2
    clr_ram(0);
    ram[5][5] = 1; ram[4][4] = 1; ram[6][6] = 1;
    req(5, 5, 8'hFF);
    wait_res(0);
    chk_res("t2a", 5, 5, 2, 1, 9);
    take();

    // 2b: die of overcrowding with 4
    ram[5][4] = 1; ram[5][6] = 1;
    req(5, 5, 8'hFF);
    wait_res(0);
    chk_res("t2b", 5, 5, 4, 0, 9);
    take();

    // 2c: dead cell with 2 stays dead
    clr_ram(0);
    ram[4][4] = 1; ram[6][6] = 1;
    req(5, 5, 8'hFF);
    wait_res(0);
    chk_res("t2c", 5, 5, 2, 0, 9);
    take();

    // 3: corner, only neighbours 4,6,7 relevant, field fully live
    clr_ram(1);
    req(0, 0, 8'b1101_0000);
    wait_res(0);
    chk_res("t3", 0, 0, 3, 1, 4);
    chk("t3_rd1_x", rdx_q[1], 1);
    chk("t3_rd1_y", rdy_q[1], 0);
    chk("t3_rd3_x", rdx_q[3], 1);
    chk("t3_rd3_y", rdy_q[3], 1);
    take();

    // 4: consumer stall
    clr_ram(0);
    ram[20][10] = 1; ram[19][9] = 1; ram[19][10] = 1;
    req(10, 20, 8'hFF);
    wait_res(0);
    chk_res("t4", 10, 20, 2, 1, 9);
    hold_cnt = o_res_nbr_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("t4_hold_vld", o_res_vld, 1);
      chk("t4_hold_cnt", o_res_nbr_cnt, hold_cnt);
      chk("t4_hold_x", o_res_x_adr, 10);
      chk("t4_hold_y", o_res_y_adr, 20);
      chk("t4_hold_st", o_res_state, 1);
      chk("t4_no_rd", o_rd_en, 0);
      chk("t4_req_rdy", o_req_rdy, 0);
    end
    chk("t4_reads_total", rdx_q.size(), 9);
    take();

    // 5: reset during slot 4, then a fresh evaluation
    clr_ram(0);
    ram[5][5] = 1;
    ram[4][4] = 1; ram[4][5] = 1; ram[4][6] = 1;
    req(5, 5, 8'hFF);
    repeat (4) @(posedge clk);
    #1 chk("t5_mid_read", o_rd_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_rd_en", o_rd_en, 0);
    chk("t5_rst_req_rdy", o_req_rdy, 1);
    chk("t5_rst_vld", o_res_vld, 0);
    chk("t5_rst_cnt", o_res_nbr_cnt, 0);
    chk("t5_rst_rd_x", o_rd_x_adr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req(5, 5, 8'hFF);
    wait_res(0);
    chk_res("t5", 5, 5, 3, 1, 9);
    take();

    // 6: inputs change every cycle after accept
    clr_ram(0);
    ram[4][4] = 1; ram[4][5] = 1; ram[4][6] = 1;
    req(5, 5, 8'hFF);
    wait_res(1);
    chk_res("t6", 5, 5, 3, 1, 9);
    chk("t6_rd0_x", rdx_q[0], 5);
    chk("t6_rd8_x", rdx_q[8], 6);
    chk("t6_rd8_y", rdy_q[8], 6);
    take();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nbr_state_eval.md
Name: nbr_state_eval

Overview:
- Sequential stage directly downstream of the neighbour-address generator.
- Per cell, it takes the cell address plus 8 neighbour addresses and relevance flags, and reads the current-generation field RAM one cell per cycle.
- It counts live relevant neighbours, applies the Life rule (B3/S23), and emits the next-generation state with a valid/ready handshake.
- It feeds the next-generation write stage.

Parameters:
- FIELD_W, 30, field width in cells.
- FIELD_H, 50, field height in cells.
- X_ADR_SIZE, $clog2(FIELD_W), localparam, x address width.
- Y_ADR_SIZE, $clog2(FIELD_H), localparam, y address width.
- NEIGHBOURS_CNT, 8, localparam, fixed.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_vld  in  1  request valid.
- o_req_rdy  out  1  block can accept a request.
- i_cell_x_adr  in  X_ADR_SIZE  evaluated cell x.
- i_cell_y_adr  in  Y_ADR_SIZE  evaluated cell y.
- i_nbrs_x_adr  in  X_ADR_SIZE x [8]  neighbour x, numbered 0..7 row-major around the cell.
- i_nbrs_y_adr  in  Y_ADR_SIZE x [8]  neighbour y.
- i_nbrs_rlvnt  in  1 x [8]  neighbour lies inside the field.
- o_rd_en  out  1  field RAM read strobe.
- o_rd_x_adr  out  X_ADR_SIZE  read x.
- o_rd_y_adr  out  Y_ADR_SIZE  read y.
- i_rd_data  in  1  cell state; valid exactly 1 cycle after o_rd_en.
- o_res_vld  out  1  result valid.
- i_res_rdy  in  1  consumer accepts result.
- o_res_x_adr  out  X_ADR_SIZE  evaluated cell x.
- o_res_y_adr  out  Y_ADR_SIZE  evaluated cell y.
- o_res_state  out  1  next-generation state.
- o_res_nbr_cnt  out  4  live relevant neighbour count, 0..8.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; it applies immediately, even mid-evaluation.
- Reset values: FSM=IDLE, o_req_rdy=1 (o_req_rdy = state==IDLE), all other outputs 0, internal count, index and own-state registers 0. No handshake is accepted while i_rst_n is low.
- Request handshake: occurs on a clock edge with i_req_vld&&o_req_rdy. All request inputs are captured on that edge and are ignored afterwards.
- IDLE: on handshake, go to READ with slot idx=0.
- READ: one slot per cycle, idx 0..8.
  - Slot 0 reads the cell itself; o_rd_en=1.
  - Slot k (1..8) reads neighbour k-1; o_rd_en = captured rlvnt[k-1].
  - Irrelevant slots issue no read but still consume one cycle, so latency is fixed.
  - o_rd_x/y_adr carry the slot address when o_rd_en=1, else 0.
  - After slot 8, go to LAST.
- Data path:
  - rd_pend (o_rd_en delayed 1 cycle) plus a registered slot index select where i_rd_data goes.
  - Slot 0 data goes to the own-state register.
  - Slots 1..8 add i_rd_data to the 4-bit count, which cannot overflow (max 8).
  - Unrelevant neighbours contribute 0.
- LAST: absorb slot 8 data, then go to DONE.
- DONE:
  - o_res_vld=1. o_res_state = (cnt==3) | (own & cnt==2).
  - All o_res_* outputs are held stable until i_res_rdy.
  - On i_res_vld&&i_res_rdy edge: go to IDLE, o_res_vld drops.
- Timing:
  - Latency: o_res_vld rises after the 11th edge counting the accept edge as 1.
  - Minimum request spacing is 12 cycles.
  - i_res_rdy held low stalls indefinitely with no reads issued.
- i_rd_data is ignored in any cycle not preceded by o_rd_en=1.

Optional Feature:
- Macro: NBR_STATE_EVAL_TORUS_EN.
- Defined: toroidal field.
  - i_nbrs_rlvnt is ignored; all 8 neighbours are read.
  - Addresses are recomputed from the captured cell address:
    - x-1 at x==0 becomes FIELD_W-1; x+1 at x==FIELD_W-1 becomes 0.
    - y-1 at y==0 becomes FIELD_H-1; y+1 at y==FIELD_H-1 becomes 0.
  - Interior cells use the input addresses unchanged.
- Undefined: planar behaviour as above; the wrap logic is absent.

Decomposition:
- life_pkg:
  - NEIGHBOURS_CNT=8, NBR_CNT_W=4, BIRTH_CNT=3, SURVIVE_CNT=2.
  - eval_state_t enum {IDLE, READ, LAST, DONE}.
  - Function next_state(own, cnt).
- One sub-module, nbr_wrap_adr: the combinational torus address correction, instantiated only under NBR_STATE_EVAL_TORUS_EN.

Test Plan:
1. Cell (5,5), all relevant, RAM: own=0, neighbours 0,1,2 live -> 9 consecutive reads, o_res_nbr_cnt=3, o_res_state=1, o_res_vld at edge 11.
2. Cell (5,5), own=1, 2 live neighbours -> state 1. Own=1, 4 live -> state 0. Own=0, 2 live -> state 0.
3. Corner (0,0), rlvnt only {4,6,7}, RAM fully live -> exactly 4 o_rd_en pulses, cnt=3, state=1. Under TORUS_EN: 9 reads incl. (29,49), cnt=8, state=0.
4. Hold i_res_rdy=0 for 20 cycles in DONE -> outputs stable, o_req_rdy=0, no o_rd_en. Release -> IDLE next edge, o_req_rdy=1.
5. Assert i_rst_n=0 mid-READ (slot 4) -> immediately all outputs 0, o_req_rdy=1. A new request after release evaluates correctly, with no stale count.
6. Change i_nbrs_* every cycle after the accept edge -> result depends only on the captured values.
